// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM states, error codes and helpers for the instruction/data memory
package mem_pkg;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_IPROT    = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// rtl/sp_ram_be.sv - single-port word array, synchronous byte-enable write, asynchronous read
module sp_ram_be
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int AW    = clog2(DEPTH),
  localparam int BW    = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BW-1:0]     be_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Storage is deliberately never reset so the instruction region survives a reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BW; k++) begin
      if (we_i && be_i[k]) mem_q[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/inst_data_mem_ctrl.sv
// rtl/inst_data_mem_ctrl.sv - unified instruction/data memory with handshake, latency and error decode
module inst_data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 256,
  parameter int INST_WORDS    = 32,
  parameter int LATENCY       = 1,
  parameter int INST_WRITABLE = 0,
  localparam int AW           = clog2(DEPTH),
  localparam int BW           = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BW-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              init_done_q, init_done_d;

  logic              idle, in_init, enter_resp, acc_err;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [BW-1:0]     cur_be;
  logic [1:0]        err_code;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [BW-1:0]     ram_be;

  function automatic logic [1:0] decode_err(input logic we, input logic [31:0] addr);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if (addr >= 32'(DEPTH * 4)) return ERR_RANGE;
    if (we && (INST_WRITABLE == 0) && (addr[AW+1:2] < AW'(INST_WORDS))) return ERR_IPROT;
    return ERR_NONE;
  endfunction

  assign idle    = (state_q == IDLE);
  assign in_init = (state_q == INIT);

  // With LATENCY==1 the commit edge is the accepting edge, so the live request is used directly.
  assign cur_we    = idle ? req_we    : we_q;
  assign cur_addr  = idle ? req_addr  : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign cur_be    = idle ? req_be    : be_q;

  assign err_code   = decode_err(cur_we, cur_addr);
  assign acc_err    = (err_code != ERR_NONE);
  assign enter_resp = (idle && req_valid && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));

  assign ram_addr  = in_init ? idx_q : cur_addr[AW+1:2];
  assign ram_wdata = in_init ? '0    : cur_wdata;
  assign ram_be    = in_init ? '1    : cur_be;
  assign ram_we    = in_init || (enter_resp && cur_we && !acc_err);

  sp_ram_be #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .be_i   (ram_be),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || cur_we) ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      idx_q       <= AW'(INST_WORDS);
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign init_done = init_done_q;

endmodule
